// File: rtl/coin_pkg.sv
// Shared constants and types for the coin spawner and the coin-collision block.
package coin_pkg;

  localparam logic [9:0]  X_LEFT     = 10'd144;
  localparam logic [9:0]  X_RIGHT    = 10'd783;
  localparam logic [9:0]  Y_BASE     = 10'd120;
  localparam logic [2:0]  SPEED_INIT = 3'd2;
  localparam logic [2:0]  SPEED_MAX  = 3'd5;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    GS_START    = 2'd0,
    GS_PLAYING  = 2'd1,
    GS_OVER     = 2'd2,
    GS_OVER_ALT = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } fsm_state_e;

  function automatic fsm_state_e decode_state(input logic [1:0] gs);
    fsm_state_e st;
    case (gs)
      GS_START:   st = ST_IDLE;
      GS_PLAYING: st = ST_RUN;
      default:    st = ST_FROZEN;
    endcase
    return st;
  endfunction

  // Fibonacci step, taps 16,14,13,11 (1-indexed), shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/coin_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR with enable; source of the coin respawn heights.
module lfsr16 import coin_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next state: advance only when enabled.
  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = lfsr_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/coin_spawner.sv
// Scrolls two coins leftward once per frame, respawning them at the right edge
// with pseudo-random heights and raising scroll speed as coins are respawned.
module coin_spawner import coin_pkg::*; #(
  parameter logic [9:0] X_RIGHT    = coin_pkg::X_RIGHT,
  parameter logic [9:0] X_LEFT     = coin_pkg::X_LEFT,
  parameter logic [9:0] Y_BASE     = coin_pkg::Y_BASE,
  parameter logic [2:0] SPEED_INIT = coin_pkg::SPEED_INIT,
  parameter logic [2:0] SPEED_MAX  = coin_pkg::SPEED_MAX
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [1:0] game_state,
  input  logic       coin1_collected,
  input  logic       coin2_collected,
  output logic [9:0] coin1_X_Pos,
  output logic [9:0] coin1_Y_Pos,
  output logic [9:0] coin2_X_Pos,
  output logic [9:0] coin2_Y_Pos,
  output logic       coin1_visible,
  output logic       coin2_visible,
  output logic [2:0] speed
);

  localparam logic [9:0] X1_INIT = X_RIGHT;
  localparam logic [9:0] Y1_INIT = Y_BASE + 10'd64;
  localparam logic [9:0] X2_INIT = X_RIGHT - 10'd320;
  localparam logic [9:0] Y2_INIT = Y_BASE + 10'd128;

  fsm_state_e  state_q;
  logic [9:0]  coin1_x_q, coin1_y_q, coin2_x_q, coin2_y_q;
  logic [2:0]  speed_q;
  logic [3:0]  cnt_q;
  logic        sync1_q, sync2_q, sync3_q;

  logic        frame_tick_s;
  logic        lfsr_en_s;
  logic [15:0] lfsr_s;
  logic        wrap1_s, wrap2_s;
  logic [9:0]  coin1_x_d, coin1_y_d, coin2_x_d, coin2_y_d;
  logic [4:0]  cnt_sum_s;
  logic        crossed_s;
  logic [2:0]  speed_d;
  logic [3:0]  cnt_d;

  // Move left by spd, clamped so the coin rests exactly on X_LEFT for one frame.
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic [2:0] spd);
    logic [10:0] diff;
    diff = {1'b0, x} - {8'd0, spd};
    if (diff <= {1'b0, X_LEFT}) begin
      return X_LEFT;
    end else begin
      return diff[9:0];
    end
  endfunction

  // Frame strobe synchronizer and rising-edge register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign frame_tick_s = sync2_q & ~sync3_q;
  assign lfsr_en_s    = frame_tick_s && (state_q == ST_RUN);

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .en_i    (lfsr_en_s),
    .state_o (lfsr_s)
  );

  // Per-frame motion, respawn and speed-up candidates; committed only on a RUN tick.
  always_comb begin
    wrap1_s   = (coin1_x_q <= X_LEFT);
    wrap2_s   = (coin2_x_q <= X_LEFT);
    coin1_x_d = wrap1_s ? X_RIGHT : step_x(coin1_x_q, speed_q);
    coin2_x_d = wrap2_s ? X_RIGHT : step_x(coin2_x_q, speed_q);
    coin1_y_d = wrap1_s ? (Y_BASE + {2'b00, lfsr_s[7:0]}) : coin1_y_q;
    coin2_y_d = wrap2_s ? (Y_BASE + {2'b00, lfsr_s[15:8]}) : coin2_y_q;
    cnt_sum_s = {1'b0, cnt_q} + {4'd0, wrap1_s} + {4'd0, wrap2_s};
    crossed_s = (cnt_sum_s[4:3] != {1'b0, cnt_q[3]});
    cnt_d     = cnt_sum_s[3:0];
    speed_d   = (crossed_s && (speed_q < SPEED_MAX)) ? (speed_q + 3'd1) : speed_q;
  end

  // Game FSM with registered coin state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      coin1_x_q <= X1_INIT;
      coin1_y_q <= Y1_INIT;
      coin2_x_q <= X2_INIT;
      coin2_y_q <= Y2_INIT;
      speed_q   <= SPEED_INIT;
      cnt_q     <= 4'd0;
    end else begin
      state_q <= decode_state(game_state);
      case (state_q)
        ST_RUN: begin
          if (frame_tick_s) begin
            coin1_x_q <= coin1_x_d;
            coin1_y_q <= coin1_y_d;
            coin2_x_q <= coin2_x_d;
            coin2_y_q <= coin2_y_d;
            speed_q   <= speed_d;
            cnt_q     <= cnt_d;
          end
        end
        ST_FROZEN: begin
        end
        default: begin
          coin1_x_q <= X1_INIT;
          coin1_y_q <= Y1_INIT;
          coin2_x_q <= X2_INIT;
          coin2_y_q <= Y2_INIT;
          speed_q   <= SPEED_INIT;
          cnt_q     <= 4'd0;
        end
      endcase
    end
  end

  assign coin1_X_Pos   = coin1_x_q;
  assign coin1_Y_Pos   = coin1_y_q;
  assign coin2_X_Pos   = coin2_x_q;
  assign coin2_Y_Pos   = coin2_y_q;
  assign speed         = speed_q;
  assign coin1_visible = ((state_q == ST_RUN) || (state_q == ST_FROZEN)) &&
                         !coin1_collected && (coin1_x_q > X_LEFT);
  assign coin2_visible = ((state_q == ST_RUN) || (state_q == ST_FROZEN)) &&
                         !coin2_collected && (coin2_x_q > X_LEFT);

endmodule

// File: tb/tb_coin_spawner.sv
// Bench for coin_spawner: a default instance plus a degenerate-range instance
// (X_RIGHT == X_LEFT) in which both coins respawn together on every frame.
module tb_coin_spawner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [1:0] game_state;
  logic       c1col, c2col;

  logic [9:0] o_x1 [2];
  logic [9:0] o_y1 [2];
  logic [9:0] o_x2 [2];
  logic [9:0] o_y2 [2];
  logic       o_v1 [2];
  logic       o_v2 [2];
  logic [2:0] o_spd [2];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  localparam int YB = 120;
  int XR [2] = '{783, 500};
  int XL [2] = '{144, 500};

  int          m_x [2][2];
  int          m_y [2][2];
  int          m_spd [2];
  int          m_cnt [2];
  int          m_resp [2];
  logic [15:0] m_lfsr [2];
  int          m_mode;

  always #5 Clk = ~Clk;

  coin_spawner dut_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_state(game_state),
    .coin1_collected(c1col), .coin2_collected(c2col),
    .coin1_X_Pos(o_x1[0]), .coin1_Y_Pos(o_y1[0]),
    .coin2_X_Pos(o_x2[0]), .coin2_Y_Pos(o_y2[0]),
    .coin1_visible(o_v1[0]), .coin2_visible(o_v2[0]), .speed(o_spd[0])
  );

  coin_spawner #(.X_RIGHT(10'd500), .X_LEFT(10'd500)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_state(game_state),
    .coin1_collected(c1col), .coin2_collected(c2col),
    .coin1_X_Pos(o_x1[1]), .coin1_Y_Pos(o_y1[1]),
    .coin2_X_Pos(o_x2[1]), .coin2_Y_Pos(o_y2[1]),
    .coin1_visible(o_v1[1]), .coin2_visible(o_v2[1]), .speed(o_spd[1])
  );

  task automatic cmp(input string nm, input int inst, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic void model_init(input int i);
    m_x[i][0] = XR[i];       m_y[i][0] = YB + 64;
    m_x[i][1] = XR[i] - 320; m_y[i][1] = YB + 128;
    m_spd[i] = 2; m_cnt[i] = 0; m_resp[i] = 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      model_init(i);
      m_lfsr[i] = 16'hACE1;
    end
  endfunction

  function automatic void model_step(input int i);
    int wraps;
    logic [15:0] old;
    if (m_mode != 1) return;
    wraps = 0;
    old = m_lfsr[i];
    for (int c = 0; c < 2; c++) begin
      if (m_x[i][c] <= XL[i]) begin
        m_x[i][c] = XR[i];
        m_y[i][c] = YB + ((c == 0) ? int'(old[7:0]) : int'(old[15:8]));
        wraps++;
      end else begin
        m_x[i][c] = m_x[i][c] - m_spd[i];
        if (m_x[i][c] < XL[i]) m_x[i][c] = XL[i];
      end
    end
    if ((m_cnt[i] / 8) != ((m_cnt[i] + wraps) / 8) && m_spd[i] < 5) m_spd[i]++;
    m_cnt[i] = (m_cnt[i] + wraps) % 16;
    m_resp[i] += wraps;
    m_lfsr[i] = lfsr_adv(old);
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        cmp("coin1_x", i, int'(o_x1[i]), m_x[i][0]);
        cmp("coin1_y", i, int'(o_y1[i]), m_y[i][0]);
        cmp("coin2_x", i, int'(o_x2[i]), m_x[i][1]);
        cmp("coin2_y", i, int'(o_y2[i]), m_y[i][1]);
        cmp("speed", i, int'(o_spd[i]), m_spd[i]);
        cmp("coin1_vis", i, int'(o_v1[i]),
            (m_mode != 0 && !c1col && m_x[i][0] > XL[i]) ? 1 : 0);
        cmp("coin2_vis", i, int'(o_v2[i]),
            (m_mode != 0 && !c2col && m_x[i][1] > XL[i]) ? 1 : 0);
      end
    end
  end

  task automatic frame_pulse();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    model_step(0);
    model_step(1);
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic set_gs(input logic [1:0] v);
    chk_en = 1'b0;
    @(negedge Clk);
    game_state = v;
    repeat (3) @(posedge Clk);
    m_mode = (v == 2'd0) ? 0 : ((v == 2'd1) ? 1 : 2);
    if (m_mode == 0) begin
      model_init(0);
      model_init(1);
    end
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bit seen8, seen16, seen24;
    Reset = 1'b1; frame_clk = 1'b0; game_state = 2'd0; c1col = 1'b0; c2col = 1'b0;
    m_mode = 0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    cmp("rst_x1", 0, int'(o_x1[0]), 783);
    cmp("rst_y1", 0, int'(o_y1[0]), 184);
    cmp("rst_x2", 0, int'(o_x2[0]), 463);
    cmp("rst_y2", 0, int'(o_y2[0]), 248);
    cmp("rst_spd", 0, int'(o_spd[0]), 2);
    cmp("rst_vis", 0, int'(o_v1[0]), 0);
    cmp("rst_x2", 1, int'(o_x2[1]), 180);
    @(negedge Clk);
    Reset = 1'b0;
    chk_en = 1'b1;
    repeat (4) @(posedge Clk);

    set_gs(2'd1);
    frame_pulse();
    cmp("t1_x1", 0, int'(o_x1[0]), 781);
    cmp("t1_x2", 0, int'(o_x2[0]), 461);
    cmp("t1_vis", 0, int'(o_v1[0]), 1);
    cmp("t1_x1", 1, int'(o_x1[1]), 500);
    cmp("t1_y1", 1, int'(o_y1[1]), 345);
    cmp("t1_y2", 1, int'(o_y2[1]), 292);
    cmp("model_lfsr", 0, int'(m_lfsr[0]), 32'h59C3);

    for (int t = 2; t <= 321; t++) begin
      c1col = (t >= 100 && t < 110);
      frame_pulse();
      if (t == 2)   begin cmp("t2_y1", 1, int'(o_y1[1]), 315); cmp("t2_y2", 1, int'(o_y2[1]), 209); end
      if (t == 4)   cmp("sim_spd3", 1, int'(o_spd[1]), 3);
      if (t == 8)   cmp("sim_spd4", 1, int'(o_spd[1]), 4);
      if (t == 12)  cmp("sim_spd5", 1, int'(o_spd[1]), 5);
      if (t == 16)  cmp("sim_sat", 1, int'(o_spd[1]), 5);
      if (t == 160) begin cmp("c2_clamp", 0, int'(o_x2[0]), 144); cmp("c2_vis", 0, int'(o_v2[0]), 0); end
      if (t == 161) cmp("c2_wrap", 0, int'(o_x2[0]), 783);
      if (t == 319) begin cmp("c1_145", 0, int'(o_x1[0]), 145); cmp("c1_vis", 0, int'(o_v1[0]), 1); end
      if (t == 320) begin cmp("c1_clamp", 0, int'(o_x1[0]), 144); cmp("c1_vis", 0, int'(o_v1[0]), 0); end
      if (t == 321) begin cmp("c1_wrap", 0, int'(o_x1[0]), 783); cmp("c1_spd", 0, int'(o_spd[0]), 2); end
    end

    guard = 0; seen8 = 0; seen16 = 0; seen24 = 0;
    while (m_resp[0] < 32 && guard < 6000) begin
      frame_pulse();
      guard++;
      if (!seen8 && m_resp[0] >= 8)   begin seen8 = 1;  cmp("spd_at8", 0, int'(o_spd[0]), 3); end
      if (!seen16 && m_resp[0] >= 16) begin seen16 = 1; cmp("spd_at16", 0, int'(o_spd[0]), 4); end
      if (!seen24 && m_resp[0] >= 24) begin seen24 = 1; cmp("spd_at24", 0, int'(o_spd[0]), 5); end
    end
    cmp("respawns_reached", 0, (m_resp[0] >= 32) ? 1 : 0, 1);
    cmp("spd_at32", 0, int'(o_spd[0]), 5);

    c2col = 1'b1;
    set_gs(2'd2);
    repeat (10) frame_pulse();
    cmp("frozen_spd", 0, int'(o_spd[0]), 5);
    c2col = 1'b0;
    set_gs(2'd1);
    frame_pulse();
    set_gs(2'd3);
    repeat (2) frame_pulse();
    set_gs(2'd1);
    frame_pulse();

    set_gs(2'd0);
    frame_pulse();
    cmp("idle_x1", 0, int'(o_x1[0]), 783);
    cmp("idle_x2", 0, int'(o_x2[0]), 463);
    cmp("idle_spd", 0, int'(o_spd[0]), 2);
    cmp("idle_vis", 0, int'(o_v1[0]), 0);

    set_gs(2'd1);
    repeat (3) frame_pulse();
    cmp("run3_x1", 0, int'(o_x1[0]), 777);
    chk_en = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    cmp("rstmid_x1", 0, int'(o_x1[0]), 783);
    cmp("rstmid_x2", 0, int'(o_x2[0]), 463);
    cmp("rstmid_spd", 0, int'(o_spd[0]), 2);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    m_mode = 1;
    repeat (3) @(posedge Clk);
    #1 chk_en = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    cmp("post_rst_x1", 0, int'(o_x1[0]), 783);
    frame_pulse();
    cmp("post_rst_tick", 0, int'(o_x1[0]), 781);
    cmp("post_rst_x2", 0, int'(o_x2[0]), 461);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/coin_spawner.md
COIN_SPAWNER -- requirements
Module: coin_spawner

Interface
REQ-001 Parameter X_RIGHT, default 783: respawn X, right edge of active area.
REQ-002 Parameter X_LEFT, default 144: wrap threshold, left edge of active area.
REQ-003 Parameter Y_BASE, default 120: minimum coin Y.
REQ-004 Parameter SPEED_INIT, default 2; SPEED_MAX, default 5: pixels moved per frame.
REQ-005 Clk  in  1  system clock; the only clock.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 frame_clk  in  1  frame strobe, asynchronous to Clk.
REQ-008 game_state  in  2  0=start, 1=playing, 2=game over, 3=treated as 2.
REQ-009 coin1_collected, coin2_collected  in  1 each  collected flags from the coin-collision block.
REQ-010 coin1_X_Pos, coin1_Y_Pos, coin2_X_Pos, coin2_Y_Pos  out  10 each  coin centre coordinates.
REQ-011 coin1_visible, coin2_visible  out  1 each  coin drawn when high.
REQ-012 speed  out  3  current scroll speed.

Function
REQ-013 frame_clk SHALL pass through a 2-flop synchronizer plus edge register; frame_tick = synced high and previous low, one Clk wide.
REQ-014 Registered outputs SHALL update on the Clk edge where frame_tick is high: 3 Clk cycles after frame_clk rises.
REQ-015 FSM states: IDLE, RUN, FROZEN; game_state 0 -> IDLE, 1 -> RUN, 2/3 -> FROZEN, evaluated every Clk cycle.
REQ-016 IDLE: coin1 = (X_RIGHT, Y_BASE+64), coin2 = (X_RIGHT-320, Y_BASE+128), speed = SPEED_INIT, respawn counter = 0, LFSR held.
REQ-017 FROZEN: all positions, speed, counter and LFSR hold.
REQ-018 RUN, per frame_tick, per coin: if X <= X_LEFT, X := X_RIGHT and Y := new random Y; else X := max(X - speed, X_LEFT).
REQ-019 Clamping in REQ-018 SHALL guarantee exactly one tick with X == X_LEFT before wrap, so the collision block clears its flag.
REQ-020 X subtraction SHALL use 11-bit arithmetic; no 10-bit underflow permitted.
REQ-021 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advances once per frame_tick in RUN only.
REQ-022 Random Y: coin1 uses Y_BASE + lfsr[7:0], coin2 uses Y_BASE + lfsr[15:8] (range Y_BASE..Y_BASE+255), both from the pre-advance LFSR value.
REQ-023 Simultaneous wrap of both coins: both respawn in the same tick, each with its own Y slice, and the counter adds 2.
REQ-024 Respawn counter: 4 bits; on crossing a multiple of 8, speed increments, saturating at SPEED_MAX; counter wraps modulo 16.
REQ-025 coinN_visible = (state == RUN or FROZEN) and not coinN_collected and X > X_LEFT; combinational from registered state.
REQ-026 collected inputs SHALL NOT alter position or speed.

Reset
REQ-027 Reset asserted: state = IDLE, positions per REQ-016, speed = SPEED_INIT, counter = 0, LFSR = 16'hACE1, synchronizer flops = 0; takes effect immediately.
REQ-028 Reset mid-RUN: no partial update; first post-release tick is handled from IDLE or RUN values per game_state.

Structure
REQ-029 Package coin_pkg: X_LEFT, X_RIGHT, Y_BASE, SPEED_INIT, SPEED_MAX, LFSR_SEED, game_state enum, FSM state enum; shared with the coin-collision block.
REQ-030 One sub-module, lfsr16, with enable, async reset and 16-bit state output.

Verification
REQ-031 Reset, then game_state=1 and one frame_clk pulse -> coin1_X 783->781, coin2_X 463->461 exactly 3 Clk after the edge.
REQ-032 coin1_X=145 with speed 2, one tick -> X=144 with coin1_visible=0; next tick -> X=783 and Y=Y_BASE+lfsr[7:0].
REQ-033 Force both coins to 144, one tick -> both X=783, Y values from different LFSR bytes, counter +2.
REQ-034 8 respawns -> speed 3; 32 respawns -> speed saturates at 5.
REQ-035 game_state=2 over 10 frame ticks -> all outputs constant; return to 1 -> motion resumes from held values.
REQ-036 Reset asserted between frame_clk edge and tick -> positions 783/463, no decrement observed.
